rtc_set_ctrl: RTL and testbench
===============================

# rtc_set_ctrl

Controller that owns the load port of `rtc_counter` (`synced`, `hour_in`, `min_in`, `sec_in`). It arbitrates between two time sources: a user edit session driven by three debounced buttons, and an external sync source such as a network or GPS parser with a valid/ready handshake. It issues exactly one single-cycle `synced` pulse per accepted update. It sits between the button/UART front-ends and `rtc_counter`, and its edit state also drives the display blink logic.

## Interface
- `CLK_FREQ`, 50_000_000: clock frequency in Hz; timebase for the timeout and blink counters.
- `TIMEOUT_S`, 10: seconds of button inactivity after which an edit session is abandoned.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `btn_mode`, `btn_up`, `btn_down` in 1 each: debounced, clk-synchronous button levels.
- `rtc_hour` in 5, `rtc_min` in 6, `rtc_sec` in 6: current time from `rtc_counter`.
- `ext_valid` in 1: external time word valid.
- `ext_hour` in 5, `ext_min` in 6, `ext_sec` in 6: external time word.
- `ext_ready` out 1: controller can accept an external word this cycle.
- `ext_err` out 1: one-cycle pulse when an accepted external word is out of range.
- `synced` out 1: one-cycle load strobe to `rtc_counter`.
- `hour_in` out 5, `min_in` out 6, `sec_in` out 6: load value; valid while `synced`=1 and held afterwards.
- `editing` out 1: high in any EDIT state.
- `edit_field` out 2: 0 = none, 1 = hour, 2 = min, 3 = sec.
- `blink` out 1: 2 Hz square wave while editing; 0 otherwise.

## Operation
- Button edges: an edge is detected when the current sample is 1 and the previous sample is 0. The previous-sample registers reset to 1, so a button held through reset yields no edge.
- States:
  - RUN: `ext_ready`=1.
    - `ext_valid` with `ext_ready` asserted is a handshake. If `ext_hour`<24, `ext_min`<60 and `ext_sec`<60, load the outputs and go to LOAD. Otherwise pulse `ext_err` and stay in RUN.
    - Mode edge in RUN (with no handshake that cycle): snapshot `rtc_hour`/`rtc_min`/`rtc_sec` into the edit registers and go to EDIT_H.
  - Simultaneous handshake and mode edge in RUN: the external word wins and the mode edge is dropped.
  - EDIT_H, EDIT_M, EDIT_S: `ext_ready`=0, so external words stall.
    - Up edge increments the selected field; down edge decrements it.
    - Hour wraps 23→0 and 0→23. Minutes and seconds wrap 59→0 and 0→59.
    - Up and down edges in the same cycle: no change, but the timeout is still restarted.
    - Mode edge: EDIT_H→EDIT_M→EDIT_S→COMMIT.
  - COMMIT: copy the edit registers to `hour_in`/`min_in`/`sec_in`, then go to LOAD.
  - LOAD: `synced`=1 for exactly this cycle, `ext_ready`=0, then go to RUN.
- Timeout: the counter clears on entry to EDIT_H and on any button edge while editing. When it reaches CLK_FREQ*TIMEOUT_S−1 in an EDIT state, go to RUN with no `synced` pulse; `hour_in`/`min_in`/`sec_in` are unchanged.
- Blink: a toggle counter with half-period CLK_FREQ/4 cycles. It clears on entry to EDIT_H, and `blink` is forced to 0 outside the EDIT states.

## Timing
- Reset values: state RUN; `synced`, `ext_err`, `editing`, `blink` = 0; `edit_field` = 0; `hour_in`/`min_in`/`sec_in` = 0; `ext_ready` = 1 one cycle after reset is released. All counters are 0.
- `ext_ready` is a registered output: high in RUN, low in every other state.
- External path: a handshake at edge N drives `hour_in`/`min_in`/`sec_in` and `synced`=1 during cycle N to N+1. `ext_ready` is 0 during that same cycle.
- Bad external word: a handshake at edge N gives `ext_err`=1 during cycle N to N+1. `ext_ready` stays 1.
- Edit path: a mode edge in EDIT_S at edge N gives COMMIT in cycle N+1 and `synced`=1 in cycle N+2.
- `editing` and `edit_field` update on the same edge as the state change.
- Reset asserted mid-edit or mid-LOAD: immediate return to the reset values; no `synced` pulse is produced.
- Only one `synced` pulse per accepted update. Consecutive external words need at least 2 cycles between handshakes (LOAD→RUN).

## Test plan
All scenarios run with `CLK_FREQ`=10 and `TIMEOUT_S`=10, so the timeout is 100 cycles.
1. External load: `ext_valid`=1 with 10:20:30 in RUN → one `synced` pulse the next cycle, `hour_in`/`min_in`/`sec_in`=10/20/30, `rtc_counter` reads 10:20:30.
2. Bad external word: `ext_valid`=1 with 24:00:00 → one `ext_err` pulse, no `synced`, outputs keep their old value.
3. Edit with wrap: RUN at 23:59:58.
   - Stimulus: mode, up (hour→0), mode, up (min→0), mode, down×59 (sec 58→59).
   - Then mode: `synced` pulses with 00:00:59.
   - `edit_field` steps 1, 2, 3, then 0.
4. Timeout: enter edit and press up once → after 100 idle cycles `editing`=0, no `synced`, `ext_ready`=1.
5. Priority: `ext_valid` held high during EDIT_M → `ext_ready`=0, word not taken. After commit, the word is accepted in RUN, giving 2 `synced` pulses in total.
6. Reset mid-edit: assert `rst` in EDIT_M → all outputs are 0 immediately and no `synced` pulse follows reset release.

Source files
------------

// File: rtl/rtc_set_ctrl.sv
// ---------------------------------------------------------------------------
// rtc_set_ctrl
//
// Owns the load port of rtc_counter. Arbitrates between a button-driven edit
// session (mode/up/down) and an external time source with a valid/ready
// handshake, and issues one single-cycle 'synced' strobe per accepted update.
//
// Ports:
//   clk, rst                       system clock, async active-high reset
//   btn_mode, btn_up, btn_down     debounced, clk-synchronous button levels
//   rtc_hour/min/sec               current time from rtc_counter (edit snapshot)
//   ext_valid, ext_hour/min/sec    external time word
//   ext_ready                      external word can be accepted this cycle
//   ext_err                        pulse: accepted external word out of range
//   synced                         one-cycle load strobe to rtc_counter
//   hour_in/min_in/sec_in          load value, held after the strobe
//   editing, edit_field            edit session status (0 none,1 h,2 m,3 s)
//   blink                          square wave for the display while editing
// ---------------------------------------------------------------------------
module rtc_set_ctrl #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int TIMEOUT_S = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [4:0] rtc_hour,
  input  logic [5:0] rtc_min,
  input  logic [5:0] rtc_sec,
  input  logic       ext_valid,
  input  logic [4:0] ext_hour,
  input  logic [5:0] ext_min,
  input  logic [5:0] ext_sec,
  output logic       ext_ready,
  output logic       ext_err,
  output logic       synced,
  output logic [4:0] hour_in,
  output logic [5:0] min_in,
  output logic [5:0] sec_in,
  output logic       editing,
  output logic [1:0] edit_field,
  output logic       blink
);

  localparam int TIMEOUT_CYC = CLK_FREQ * TIMEOUT_S;
  localparam int TW          = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int BLINK_HALF  = (CLK_FREQ / 4 > 0) ? CLK_FREQ / 4 : 1;
  localparam int BW          = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_HALF - 1);

  localparam logic [2:0] ST_RUN    = 3'd0;
  localparam logic [2:0] ST_EDIT_H = 3'd1;
  localparam logic [2:0] ST_EDIT_M = 3'd2;
  localparam logic [2:0] ST_EDIT_S = 3'd3;
  localparam logic [2:0] ST_COMMIT = 3'd4;
  localparam logic [2:0] ST_LOAD   = 3'd5;

  logic [2:0]    state, next_state;
  logic          mode_prev, up_prev, down_prev;
  logic          mode_edge, up_edge, down_edge, any_edge;
  logic          in_edit, next_in_edit;
  logic          handshake, ext_ok, timed_out;
  logic [4:0]    edit_hour;
  logic [5:0]    edit_min, edit_sec;
  logic [5:0]    hour_step, min_step, sec_step;
  logic [TW-1:0] tmo_cnt;
  logic [BW-1:0] blink_cnt;

  // Wrapping +1/-1 on a field whose legal range is 0..top.
  function automatic logic [5:0] step_field(input logic [5:0] value,
                                            input logic [5:0] top,
                                            input logic       inc);
    if (inc)
      return (value >= top) ? 6'd0 : value + 6'd1;
    else
      return (value == 6'd0 || value > top) ? top : value - 6'd1;
  endfunction

  assign mode_edge = btn_mode & ~mode_prev;
  assign up_edge   = btn_up & ~up_prev;
  assign down_edge = btn_down & ~down_prev;
  assign any_edge  = mode_edge | up_edge | down_edge;

  assign in_edit      = (state == ST_EDIT_H) || (state == ST_EDIT_M) || (state == ST_EDIT_S);
  assign next_in_edit = (next_state == ST_EDIT_H) || (next_state == ST_EDIT_M) ||
                        (next_state == ST_EDIT_S);

  // ext_ready is only ever high in RUN, so this is the RUN-state handshake.
  assign handshake = ext_ready & ext_valid;
  assign ext_ok    = (ext_hour < 5'd24) && (ext_min < 6'd60) && (ext_sec < 6'd60);

  // Any button activity wins over an expiring timeout in the same cycle.
  assign timed_out = in_edit && !any_edge && (tmo_cnt == TIMEOUT_LAST);

  assign hour_step = step_field({1'b0, edit_hour}, 6'd23, up_edge);
  assign min_step  = step_field(edit_min, 6'd59, up_edge);
  assign sec_step  = step_field(edit_sec, 6'd59, up_edge);

  // Previous button samples start at 1 so a button held through reset is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_prev <= 1'b1;
      up_prev   <= 1'b1;
      down_prev <= 1'b1;
    end else begin
      mode_prev <= btn_mode;
      up_prev   <= btn_up;
      down_prev <= btn_down;
    end
  end

  // Next-state logic; an external handshake in RUN takes priority over a mode edge.
  always_comb begin
    next_state = state;
    case (state)
      ST_RUN: begin
        if (handshake) begin
          if (ext_ok) next_state = ST_LOAD;
        end else if (mode_edge) begin
          next_state = ST_EDIT_H;
        end
      end
      ST_EDIT_H: if (mode_edge) next_state = ST_EDIT_M; else if (timed_out) next_state = ST_RUN;
      ST_EDIT_M: if (mode_edge) next_state = ST_EDIT_S; else if (timed_out) next_state = ST_RUN;
      ST_EDIT_S: if (mode_edge) next_state = ST_COMMIT; else if (timed_out) next_state = ST_RUN;
      ST_COMMIT: next_state = ST_LOAD;
      ST_LOAD:   next_state = ST_RUN;
      default:   next_state = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_RUN;
    else     state <= next_state;
  end

  // Edit registers: snapshot on session entry, then up/down adjust the selected
  // field. A mode edge in the same cycle advances the field and ignores up/down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edit_hour <= 5'd0;
      edit_min  <= 6'd0;
      edit_sec  <= 6'd0;
    end else if (state == ST_RUN && !handshake && mode_edge) begin
      edit_hour <= rtc_hour;
      edit_min  <= rtc_min;
      edit_sec  <= rtc_sec;
    end else if (in_edit && !mode_edge && (up_edge ^ down_edge)) begin
      case (state)
        ST_EDIT_H: edit_hour <= hour_step[4:0];
        ST_EDIT_M: edit_min  <= min_step;
        default:   edit_sec  <= sec_step;
      endcase
    end
  end

  // Inactivity counter: runs only while editing and restarts on any button edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tmo_cnt <= '0;
    else if (in_edit && !any_edge && !timed_out)
      tmo_cnt <= tmo_cnt + 1'b1;
    else
      tmo_cnt <= '0;
  end

  // Blink generator: starts low with a fresh count on entering the session and
  // is held cleared whenever the next state is not an edit state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (in_edit && next_in_edit) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink     <= ~blink;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end else begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end
  end

  // Registered outputs, all derived from the upcoming state so they change on
  // the same edge as the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_ready  <= 1'b0;
      ext_err    <= 1'b0;
      synced     <= 1'b0;
      editing    <= 1'b0;
      edit_field <= 2'd0;
      hour_in    <= 5'd0;
      min_in     <= 6'd0;
      sec_in     <= 6'd0;
    end else begin
      ext_ready <= (next_state == ST_RUN);
      ext_err   <= handshake && !ext_ok;
      synced    <= (next_state == ST_LOAD);
      editing   <= next_in_edit;
      case (next_state)
        ST_EDIT_H: edit_field <= 2'd1;
        ST_EDIT_M: edit_field <= 2'd2;
        ST_EDIT_S: edit_field <= 2'd3;
        default:   edit_field <= 2'd0;
      endcase
      if (handshake && ext_ok) begin
        hour_in <= ext_hour;
        min_in  <= ext_min;
        sec_in  <= ext_sec;
      end else if (state == ST_COMMIT) begin
        hour_in <= edit_hour;
        min_in  <= edit_min;
        sec_in  <= edit_sec;
      end
    end
  end

endmodule

// File: tb/tb_rtc_set_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rtc_set_ctrl
//
// Self-checking bench for rtc_set_ctrl with CLK_FREQ=10, TIMEOUT_S=10.
// A behavioural model of the set controller predicts every output each cycle;
// directed scenarios are followed by a randomized button/external-word run.
// ---------------------------------------------------------------------------
module tb_rtc_set_ctrl;

  localparam int CLK_FREQ    = 10;
  localparam int TIMEOUT_S   = 10;
  localparam int TIMEOUT_CYC = CLK_FREQ * TIMEOUT_S;
  localparam int BLINK_HALF  = CLK_FREQ / 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_mode, btn_up, btn_down;
  logic [4:0] rtc_hour;
  logic [5:0] rtc_min, rtc_sec;
  logic       ext_valid;
  logic [4:0] ext_hour;
  logic [5:0] ext_min, ext_sec;
  logic       ext_ready, ext_err, synced;
  logic [4:0] hour_in;
  logic [5:0] min_in, sec_in;
  logic       editing;
  logic [1:0] edit_field;
  logic       blink;

  int test_count = 0;
  int fail_count = 0;
  int sync_count = 0;

  // Model: phase 0 = running, 1 = editing, 2 = committing, 3 = loading
  int m_phase, m_field, m_idle, m_blink_t;
  int m_eh, m_em, m_es;
  int m_oh, m_om, m_os;
  bit m_ready, m_synced, m_err;
  bit p_mode, p_up, p_down;

  rtc_set_ctrl #(.CLK_FREQ(CLK_FREQ), .TIMEOUT_S(TIMEOUT_S)) dut (
    .clk(clk), .rst(rst),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .rtc_hour(rtc_hour), .rtc_min(rtc_min), .rtc_sec(rtc_sec),
    .ext_valid(ext_valid), .ext_hour(ext_hour), .ext_min(ext_min), .ext_sec(ext_sec),
    .ext_ready(ext_ready), .ext_err(ext_err), .synced(synced),
    .hour_in(hour_in), .min_in(min_in), .sec_in(sec_in),
    .editing(editing), .edit_field(edit_field), .blink(blink)
  );

  // 10-time-unit clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    test_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_phase = 0; m_field = 0; m_idle = 0; m_blink_t = 0;
    m_eh = 0; m_em = 0; m_es = 0;
    m_oh = 0; m_om = 0; m_os = 0;
    m_ready = 0; m_synced = 0; m_err = 0;
    p_mode = 1; p_up = 1; p_down = 1;
  endtask

  // Predicts the effect of the coming clock edge from the inputs now applied.
  task automatic modelEdge();
    bit me, ue, de;
    if (rst) begin
      modelReset();
      return;
    end
    me = btn_mode && !p_mode;
    ue = btn_up && !p_up;
    de = btn_down && !p_down;
    p_mode = btn_mode; p_up = btn_up; p_down = btn_down;
    m_err = 0;
    case (m_phase)
      3: m_phase = 0;
      2: begin
        m_oh = m_eh; m_om = m_em; m_os = m_es;
        m_phase = 3;
      end
      1: begin
        if (me || ue || de) begin
          m_idle = 0;
          if (me) begin
            if (m_field == 3) begin
              m_phase = 2;
              m_field = 0;
            end else begin
              m_field++;
            end
          end else if (ue && !de) begin
            case (m_field)
              1: m_eh = (m_eh + 1) % 24;
              2: m_em = (m_em + 1) % 60;
              default: m_es = (m_es + 1) % 60;
            endcase
          end else if (de && !ue) begin
            case (m_field)
              1: m_eh = (m_eh + 23) % 24;
              2: m_em = (m_em + 59) % 60;
              default: m_es = (m_es + 59) % 60;
            endcase
          end
        end else begin
          m_idle++;
          if (m_idle == TIMEOUT_CYC) begin
            m_phase = 0;
            m_field = 0;
          end
        end
        m_blink_t++;
      end
      default: begin
        if (m_ready && ext_valid) begin
          if (ext_hour < 24 && ext_min < 60 && ext_sec < 60) begin
            m_oh = int'(ext_hour); m_om = int'(ext_min); m_os = int'(ext_sec);
            m_phase = 3;
          end else begin
            m_err = 1;
          end
        end else if (me) begin
          m_eh = int'(rtc_hour); m_em = int'(rtc_min); m_es = int'(rtc_sec);
          m_phase = 1; m_field = 1; m_idle = 0; m_blink_t = 0;
        end
      end
    endcase
    m_ready  = (m_phase == 0);
    m_synced = (m_phase == 3);
  endtask

  task automatic checkAll();
    bit exp_edit;
    int exp_blink;
    exp_edit  = (m_phase == 1);
    exp_blink = exp_edit ? (m_blink_t / BLINK_HALF) % 2 : 0;
    checkOutput("synced", 32'(synced), 32'(m_synced));
    checkOutput("ext_ready", 32'(ext_ready), 32'(m_ready));
    checkOutput("ext_err", 32'(ext_err), 32'(m_err));
    checkOutput("editing", 32'(editing), 32'(exp_edit));
    checkOutput("edit_field", 32'(edit_field), exp_edit ? 32'(m_field) : 32'd0);
    checkOutput("blink", 32'(blink), 32'(exp_blink));
    checkOutput("load_value", {15'd0, hour_in, min_in, sec_in},
                32'(m_oh * 4096 + m_om * 64 + m_os));
  endtask

  task automatic tick();
    modelEdge();
    @(posedge clk);
    #1;
    if (synced) sync_count++;
    checkAll();
  endtask

  task automatic applyStimulus(input bit m, input bit u, input bit d, input bit v,
                               input int eh, input int em, input int es);
    btn_mode = m; btn_up = u; btn_down = d;
    ext_valid = v;
    ext_hour = 5'(eh); ext_min = 6'(em); ext_sec = 6'(es);
    tick();
  endtask

  // 0 = mode, 1 = up, 2 = down; one cycle pressed, one released
  task automatic pressButton(input int which);
    applyStimulus(which == 0, which == 1, which == 2, ext_valid,
                  int'(ext_hour), int'(ext_min), int'(ext_sec));
    applyStimulus(0, 0, 0, ext_valid, int'(ext_hour), int'(ext_min), int'(ext_sec));
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asserts reset away from the clock edge and checks the asynchronous clear.
  task automatic doReset();
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("rst_synced", 32'(synced), 32'd0);
    checkOutput("rst_editing", 32'(editing), 32'd0);
    checkOutput("rst_field", 32'(edit_field), 32'd0);
    checkOutput("rst_ready", 32'(ext_ready), 32'd0);
    checkOutput("rst_value", {15'd0, hour_in, min_in, sec_in}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    btn_mode = 0; btn_up = 0; btn_down = 0;
    ext_valid = 0; ext_hour = 0; ext_min = 0; ext_sec = 0;
    rtc_hour = 5'd12; rtc_min = 6'd34; rtc_sec = 6'd56;
    #1;
    doReset();
    idleCycles(2);
    checkOutput("ready_after_reset", 32'(ext_ready), 32'd1);

    // External load of 10:20:30
    applyStimulus(0, 0, 0, 1, 10, 20, 30);
    checkOutput("s1_synced", 32'(synced), 32'd1);
    checkOutput("s1_ready_low", 32'(ext_ready), 32'd0);
    checkOutput("s1_value", {15'd0, hour_in, min_in, sec_in}, (10 << 12) | (20 << 6) | 30);
    idleCycles(1);
    checkOutput("s1_synced_once", 32'(synced), 32'd0);

    // Out-of-range external word 24:00:00
    applyStimulus(0, 0, 0, 1, 24, 0, 0);
    checkOutput("s2_err", 32'(ext_err), 32'd1);
    checkOutput("s2_no_sync", 32'(synced), 32'd0);
    checkOutput("s2_ready", 32'(ext_ready), 32'd1);
    checkOutput("s2_value_kept", {15'd0, hour_in, min_in, sec_in}, (10 << 12) | (20 << 6) | 30);
    idleCycles(2);

    // Edit with wrap from 23:59:58 to 00:00:59
    rtc_hour = 5'd23; rtc_min = 6'd59; rtc_sec = 6'd58;
    pressButton(0);
    checkOutput("s3_field_h", 32'(edit_field), 32'd1);
    pressButton(1);
    pressButton(0);
    checkOutput("s3_field_m", 32'(edit_field), 32'd2);
    pressButton(1);
    pressButton(0);
    checkOutput("s3_field_s", 32'(edit_field), 32'd3);
    for (int i = 0; i < 59; i++) pressButton(2);
    sync_count = 0;
    pressButton(0);
    checkOutput("s3_synced", 32'(synced), 32'd1);
    checkOutput("s3_value", {15'd0, hour_in, min_in, sec_in}, 32'd59);
    checkOutput("s3_field_none", 32'(edit_field), 32'd0);
    idleCycles(2);
    checkOutput("s3_one_pulse", 32'(sync_count), 32'd1);

    // Timeout after 100 idle cycles
    sync_count = 0;
    pressButton(0);
    pressButton(1);
    idleCycles(TIMEOUT_CYC - 2);
    checkOutput("s4_still_editing", 32'(editing), 32'd1);
    idleCycles(1);
    checkOutput("s4_timeout", 32'(editing), 32'd0);
    checkOutput("s4_ready", 32'(ext_ready), 32'd1);
    checkOutput("s4_no_sync", 32'(sync_count), 32'd0);
    checkOutput("s4_value_kept", {15'd0, hour_in, min_in, sec_in}, 32'd59);

    // External word held during EDIT_M waits until the session commits
    sync_count = 0;
    pressButton(0);
    pressButton(0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, 5, 6, 7);
    checkOutput("s5_stalled", 32'(ext_ready), 32'd0);
    pressButton(0);
    pressButton(0);
    for (int i = 0; i < 8; i++) begin
      bit taking;
      taking = m_ready;
      applyStimulus(0, 0, 0, 1, 5, 6, 7);
      if (taking) break;
    end
    idleCycles(3);
    checkOutput("s5_two_pulses", 32'(sync_count), 32'd2);
    checkOutput("s5_value", {15'd0, hour_in, min_in, sec_in}, (5 << 12) | (6 << 6) | 7);

    // Reset in the middle of EDIT_M
    pressButton(0);
    pressButton(0);
    checkOutput("s6_in_edit_m", 32'(edit_field), 32'd2);
    sync_count = 0;
    doReset();
    idleCycles(5);
    checkOutput("s6_no_sync", 32'(sync_count), 32'd0);
    checkOutput("s6_ready", 32'(ext_ready), 32'd1);

    // Randomized buttons, external words and rtc values
    for (int cyc = 0; cyc < 2500; cyc++) begin
      bit m, u, d, v;
      if (cyc % 600 == 599) begin
        idleCycles(TIMEOUT_CYC + 10);
      end else if (cyc == 1300) begin
        doReset();
      end else begin
        m = ($urandom_range(0, 7) == 0) ? !btn_mode : btn_mode;
        u = ($urandom_range(0, 2) == 0) ? !btn_up : btn_up;
        d = ($urandom_range(0, 2) == 0) ? !btn_down : btn_down;
        v = ($urandom_range(0, 3) == 0);
        rtc_hour = 5'($urandom_range(0, 23));
        rtc_min  = 6'($urandom_range(0, 59));
        rtc_sec  = 6'($urandom_range(0, 59));
        applyStimulus(m, u, d, v, $urandom_range(0, 27), $urandom_range(0, 63),
                      $urandom_range(0, 63));
      end
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
